// File: rtl/timer_sched.sv
// timer_sched: round-robin scheduler that shares one timer block among NCH
// one-shot delay requesters. A granted channel gets the timer programmed
// (clear irq, counter, expiry, start), waits for the irq, clears it again
// and receives a one-cycle done pulse.
module timer_sched #(
  parameter int          NCH        = 4,
  parameter logic [29:0] TIMER_BASE = 30'h0
) (
  input  logic               clk,
  input  logic               reset_,
  input  logic [NCH-1:0]     req,
  input  logic [32*NCH-1:0]  req_cycles,
  output logic [NCH-1:0]     done,
  output logic               busy,
  output logic [2:0]         grant,
  output logic               t_cs_,
  output logic               t_as_,
  output logic               t_rw,
  output logic [29:0]        t_addr,
  output logic [31:0]        t_wr_data,
  input  logic               t_rdy_,
  input  logic               t_irq
);

  // Timer register offsets
  localparam logic [1:0] OFF_CTRL = 2'd0;
  localparam logic [1:0] OFF_INTR = 2'd1;
  localparam logic [1:0] OFF_EXPR = 2'd2;
  localparam logic [1:0] OFF_CNT  = 2'd3;

  typedef enum logic [2:0] {
    S_IDLE, S_CLR0, S_CNT, S_EXP, S_GO, S_WAIT, S_CLR1, S_FIN
  } state_t;

  state_t           r_state;
  state_t           w_state_next;
  state_t           w_after;
  logic             r_gap;
  logic             w_gap_next;
  logic [NCH-1:0]   r_pend;
  logic [31:0]      w_cyc [NCH];
  logic [31:0]      w_sel_cyc;
  logic [31:0]      r_delay;
  logic [2:0]       r_ptr;
  logic [2:0]       r_grant;
  logic             w_found;
  logic [2:0]       w_sel;
  logic             w_grant_fire;
  logic [NCH-1:0]   w_clr;
  logic             w_wr_state;
  logic [1:0]       w_off;
  logic [31:0]      w_data;

  // Per-channel delay registers and pending-clear decode
  for (genvar gi = 0; gi < NCH; gi++) begin : g_ch
    logic [31:0] r_cyc;

    // A request pulse (re)loads the channel's delay, even while pending
    always_ff @(posedge clk or negedge reset_) begin
      if (!reset_) begin
        r_cyc <= '0;
      end else if (req[gi]) begin
        r_cyc <= req_cycles[32*gi +: 32];
      end
    end

    assign w_cyc[gi] = r_cyc;
    assign w_clr[gi] = w_grant_fire && (w_sel == 3'(gi));
  end

  // Round-robin pick: lowest pending channel above the last grant, else wrap
  always_comb begin
    w_found   = 1'b0;
    w_sel     = '0;
    w_sel_cyc = '0;
    for (int j = 0; j < NCH; j++) begin
      if (!w_found && r_pend[j] && (3'(j) > r_ptr)) begin
        w_found = 1'b1;
        w_sel   = 3'(j);
      end
    end
    for (int j = 0; j < NCH; j++) begin
      if (!w_found && r_pend[j]) begin
        w_found = 1'b1;
        w_sel   = 3'(j);
      end
    end
    for (int j = 0; j < NCH; j++) begin
      if (3'(j) == w_sel) begin
        w_sel_cyc = w_cyc[j];
      end
    end
  end

  assign w_grant_fire = (r_state == S_IDLE) && w_found;

  // Pending flags: a new request wins over the grant-clear in the same cycle
  always_ff @(posedge clk or negedge reset_) begin
    if (!reset_) begin
      r_pend <= '0;
    end else begin
      r_pend <= (r_pend & ~w_clr) | req;
    end
  end

  // Grant bookkeeping; delay is frozen at grant so later requests cannot disturb it
  always_ff @(posedge clk or negedge reset_) begin
    if (!reset_) begin
      r_grant <= '0;
      r_ptr   <= 3'(NCH - 1);
      r_delay <= '0;
    end else if (w_grant_fire) begin
      r_grant <= w_sel;
      r_ptr   <= w_sel;
      r_delay <= w_sel_cyc;
    end
  end

  // FSM state and the strobe/gap phase flag of the current bus write
  always_ff @(posedge clk or negedge reset_) begin
    if (!reset_) begin
      r_state <= S_IDLE;
      r_gap   <= 1'b0;
    end else begin
      r_state <= w_state_next;
      r_gap   <= w_gap_next;
    end
  end

  // Next-state logic and bus/status outputs decoded from the state
  always_comb begin
    w_state_next = r_state;
    w_gap_next   = r_gap;
    w_after      = S_IDLE;
    w_wr_state   = 1'b0;
    w_off        = OFF_CTRL;
    w_data       = '0;
    done         = '0;

    case (r_state)
      S_CLR0: begin w_after = S_CNT;  w_wr_state = 1'b1; w_off = OFF_INTR; end
      S_CNT:  begin w_after = S_EXP;  w_wr_state = 1'b1; w_off = OFF_CNT;  end
      S_EXP:  begin w_after = S_GO;   w_wr_state = 1'b1; w_off = OFF_EXPR; w_data = r_delay; end
      S_GO:   begin w_after = S_WAIT; w_wr_state = 1'b1; w_off = OFF_CTRL; w_data = 32'h1; end
      S_CLR1: begin w_after = S_FIN;  w_wr_state = 1'b1; w_off = OFF_INTR; end
      default: ;
    endcase

    case (r_state)
      S_IDLE: begin
        w_gap_next = 1'b0;
        if (w_found) begin
          w_state_next = S_CLR0;
        end
      end
      S_CLR0, S_CNT, S_EXP, S_GO, S_CLR1: begin
        if (r_gap) begin
          w_gap_next   = 1'b0;
          w_state_next = w_after;
        end else if (!t_rdy_) begin
          w_gap_next = 1'b1;
        end
      end
      S_WAIT: begin
        if (t_irq) begin
          w_state_next = S_CLR1;
        end
      end
      S_FIN: begin
        w_state_next = S_IDLE;
        for (int j = 0; j < NCH; j++) begin
          done[j] = (r_grant == 3'(j));
        end
      end
      default: w_state_next = S_IDLE;
    endcase

    t_cs_     = !(w_wr_state && !r_gap);
    t_as_     = !(w_wr_state && !r_gap);
    t_rw      = !w_wr_state;
    t_addr    = w_wr_state ? {TIMER_BASE[29:2], w_off} : '0;
    t_wr_data = w_wr_state ? w_data : '0;
    busy      = (r_state != S_IDLE);
    grant     = r_grant;
  end

endmodule
